// File: rtl/ps2_scan_decoder.sv
// PS/2 scan-code decoder: E0/F0 prefix FSM with prefix timeout, FWFT event FIFO and last-make display register.
// Optional held-key repeat suppression: define PS2_SCAN_DECODER_TYPEMATIC_FILTER_EN.
module ps2_scan_decoder #(
  parameter int FIFO_DEPTH     = 8,
  parameter int ADDR_W         = 3,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk100Mhz,
  input  logic       resetN,
  input  logic [7:0] byteIn,
  input  logic       byteValid,
  input  logic       rdEn,
  input  logic       clrOvf,
  output logic [7:0] evCode,
  output logic       evExt,
  output logic       evBreak,
  output logic       evValid,
  output logic       fifoFull,
  output logic       overflow,
  output logic       protoErr,
  output logic [3:0] keyHi,
  output logic [3:0] keyLo,
  output logic       dispEn
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

  state_t          r_state, w_next;
  logic [TW-1:0]   r_tcnt;
  logic            w_timeout, w_is_e0, w_is_f0, w_is_noise;
  logic            w_evt, w_ext, w_brk, w_perr, w_push;
  logic            w_wr, w_pop, w_ovf_set;
  logic [ADDR_W-1:0] r_wptr, r_rptr;
  logic [ADDR_W:0]   r_cnt;
  logic [9:0]      r_mem [FIFO_DEPTH];
  logic [9:0]      w_head;
  logic [7:0]      r_last;
  logic            r_disp, r_ovf, r_perr;

  assign w_is_e0    = (byteIn == 8'hE0);
  assign w_is_f0    = (byteIn == 8'hF0);
  assign w_is_noise = (byteIn == 8'h00) || (byteIn == 8'hAA) || (byteIn == 8'hEE) ||
                      (byteIn == 8'hFA) || (byteIn == 8'hFC) || (byteIn == 8'hFE) ||
                      (byteIn == 8'hFF);
  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign w_timeout  = (r_state != S_IDLE) && !byteValid &&
                      (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk100Mhz or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_timeout) w_next = S_IDLE;
    else if (byteValid) begin
      case (r_state)
        S_IDLE:  if (w_is_e0) w_next = S_E0;
                 else if (w_is_f0) w_next = S_F0;
        S_E0:    if (w_is_f0) w_next = S_E0F0;
                 else if (!w_is_e0) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_evt  = 1'b0;
    w_ext  = 1'b0;
    w_brk  = 1'b0;
    w_perr = w_timeout;
    if (byteValid) begin
      case (r_state)
        S_IDLE: w_evt = !w_is_e0 && !w_is_f0 && !w_is_noise;
        S_E0: begin
          w_evt = !w_is_e0 && !w_is_f0;
          w_ext = 1'b1;
        end
        S_F0: begin
          w_perr = w_is_e0 || w_is_f0;
          w_evt  = !w_perr;
          w_brk  = 1'b1;
        end
        default: begin
          w_perr = w_is_e0 || w_is_f0;
          w_evt  = !w_perr;
          w_ext  = 1'b1;
          w_brk  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk100Mhz or negedge resetN) begin
    if (!resetN) r_tcnt <= '0;
    else if (byteValid || (r_state == S_IDLE) || w_timeout) r_tcnt <= '0;
    else r_tcnt <= r_tcnt + 1'b1;
  end

`ifdef PS2_SCAN_DECODER_TYPEMATIC_FILTER_EN
  logic       r_hvld, r_hext;
  logic [7:0] r_hcode;
  logic       w_match;

  assign w_match = r_hvld && (r_hext == w_ext) && (r_hcode == byteIn);
  assign w_push  = w_evt && !(w_match && !w_brk);

  always_ff @(posedge clk100Mhz or negedge resetN) begin
    if (!resetN) begin
      r_hvld  <= 1'b0;
      r_hext  <= 1'b0;
      r_hcode <= 8'h00;
    end else if (w_evt) begin
      if (w_brk) begin
        if (w_match) r_hvld <= 1'b0;
      end else if (!w_match) begin
        r_hvld  <= 1'b1;
        r_hext  <= w_ext;
        r_hcode <= byteIn;
      end
    end
  end
`else
  assign w_push = w_evt;
`endif

  assign fifoFull  = (r_cnt == (ADDR_W+1)'(FIFO_DEPTH));
  assign evValid   = (r_cnt != '0);
  assign w_pop     = rdEn && evValid;
  // When full, a push is only accepted if a pop frees the head slot in the same cycle.
  assign w_wr      = w_push && (!fifoFull || w_pop);
  assign w_ovf_set = w_push && fifoFull && !w_pop;

  always_ff @(posedge clk100Mhz) begin
    if (w_wr) r_mem[r_wptr] <= {w_ext, w_brk, byteIn};
  end

  always_ff @(posedge clk100Mhz or negedge resetN) begin
    if (!resetN) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign w_head  = evValid ? r_mem[r_rptr] : 10'h000;
  assign evExt   = w_head[9];
  assign evBreak = w_head[8];
  assign evCode  = w_head[7:0];

  always_ff @(posedge clk100Mhz or negedge resetN) begin
    if (!resetN) begin
      r_ovf  <= 1'b0;
      r_perr <= 1'b0;
      r_last <= 8'h00;
      r_disp <= 1'b0;
    end else begin
      if (w_ovf_set)   r_ovf <= 1'b1;
      else if (clrOvf) r_ovf <= 1'b0;
      if (w_perr)      r_perr <= 1'b1;
      else if (clrOvf) r_perr <= 1'b0;
      if (w_wr && !w_brk) begin
        r_last <= byteIn;
        r_disp <= 1'b1;
      end
    end
  end

  assign overflow = r_ovf;
  assign protoErr = r_perr;
  assign keyHi    = r_last[7:4];
  assign keyLo    = r_last[3:0];
  assign dispEn   = r_disp;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Directed bench for ps2_scan_decoder: per-cycle vector table plus overflow, timeout, reset and repeat-filter sequences.
module tb_ps2_scan_decoder;
  localparam int TO = 200;

  logic       clk100Mhz = 1'b0, resetN = 1'b0;
  logic [7:0] byteIn = 8'h00;
  logic       byteValid = 1'b0, rdEn = 1'b0, clrOvf = 1'b0;
  logic [7:0] evCode;
  logic       evExt, evBreak, evValid, fifoFull, overflow, protoErr, dispEn;
  logic [3:0] keyHi, keyLo;

  int checks = 0, failures = 0;

  ps2_scan_decoder #(.FIFO_DEPTH(8), .ADDR_W(3), .TIMEOUT_CYCLES(TO)) dut (
    .clk100Mhz(clk100Mhz), .resetN(resetN), .byteIn(byteIn), .byteValid(byteValid),
    .rdEn(rdEn), .clrOvf(clrOvf), .evCode(evCode), .evExt(evExt), .evBreak(evBreak),
    .evValid(evValid), .fifoFull(fifoFull), .overflow(overflow), .protoErr(protoErr),
    .keyHi(keyHi), .keyLo(keyLo), .dispEn(dispEn));

  always #5 clk100Mhz = ~clk100Mhz;

  // ctl = {byteValid, rdEn, clrOvf}; fl = {evValid, evExt, evBreak, protoErr}
  typedef struct {
    logic [7:0] b;
    logic [2:0] ctl;
    logic [7:0] code;
    logic [3:0] fl;
    logic [7:0] key;
    logic       disp;
  } vec_t;

  vec_t vt[24];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] b, input logic v, input logic rd, input logic clr);
    byteIn = b; byteValid = v; rdEn = rd; clrOvf = clr;
    @(posedge clk100Mhz); #1;
    byteValid = 1'b0; rdEn = 1'b0; clrOvf = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    #3;
    @(posedge clk100Mhz); #1;
    resetN = 1'b1;
  endtask

  task automatic chk_head(input string nm, input logic [7:0] code, input logic ext, input logic brk);
    chk({nm, "_valid"}, evValid, 1);
    chk({nm, "_entry"}, {evExt, evBreak, evCode}, {ext, brk, code});
  endtask

  initial begin
    vt[0]  = '{8'hE0, 3'b100, 8'h00, 4'b0000, 8'h00, 1'b0};
    vt[1]  = '{8'hF0, 3'b100, 8'h00, 4'b0000, 8'h00, 1'b0};
    vt[2]  = '{8'h75, 3'b100, 8'h75, 4'b1110, 8'h00, 1'b0};
    vt[3]  = '{8'h00, 3'b010, 8'h00, 4'b0000, 8'h00, 1'b0};
    vt[4]  = '{8'h1C, 3'b100, 8'h1C, 4'b1000, 8'h1C, 1'b1};
    vt[5]  = '{8'hF0, 3'b100, 8'h1C, 4'b1000, 8'h1C, 1'b1};
    vt[6]  = '{8'h1C, 3'b100, 8'h1C, 4'b1000, 8'h1C, 1'b1};
    vt[7]  = '{8'h00, 3'b010, 8'h1C, 4'b1010, 8'h1C, 1'b1};
    vt[8]  = '{8'h00, 3'b010, 8'h00, 4'b0000, 8'h1C, 1'b1};
    vt[9]  = '{8'h00, 3'b010, 8'h00, 4'b0000, 8'h1C, 1'b1};
    vt[10] = '{8'hAA, 3'b100, 8'h00, 4'b0000, 8'h1C, 1'b1};
    vt[11] = '{8'hFA, 3'b100, 8'h00, 4'b0000, 8'h1C, 1'b1};
    vt[12] = '{8'hF0, 3'b100, 8'h00, 4'b0000, 8'h1C, 1'b1};
    vt[13] = '{8'hE0, 3'b100, 8'h00, 4'b0001, 8'h1C, 1'b1};
    vt[14] = '{8'h1C, 3'b110, 8'h1C, 4'b1001, 8'h1C, 1'b1};
    vt[15] = '{8'h00, 3'b011, 8'h00, 4'b0000, 8'h1C, 1'b1};
    vt[16] = '{8'hE0, 3'b100, 8'h00, 4'b0000, 8'h1C, 1'b1};
    vt[17] = '{8'hE0, 3'b100, 8'h00, 4'b0000, 8'h1C, 1'b1};
    vt[18] = '{8'h74, 3'b100, 8'h74, 4'b1100, 8'h74, 1'b1};
    vt[19] = '{8'hF0, 3'b100, 8'h74, 4'b1100, 8'h74, 1'b1};
    vt[20] = '{8'hF0, 3'b101, 8'h74, 4'b1101, 8'h74, 1'b1};
    vt[21] = '{8'h00, 3'b010, 8'h00, 4'b0001, 8'h74, 1'b1};
    vt[22] = '{8'h00, 3'b001, 8'h00, 4'b0000, 8'h74, 1'b1};
    vt[23] = '{8'h00, 3'b100, 8'h00, 4'b0000, 8'h74, 1'b1};

    // Reset state, sampled while reset is held.
    #3;
    chk("rst_outs", {evValid, fifoFull, overflow, protoErr, dispEn, keyHi, keyLo}, 0);
    chk("rst_entry", {evExt, evBreak, evCode}, 0);
    do_reset();

    for (int i = 0; i < 24; i++) begin
      step(vt[i].b, vt[i].ctl[2], vt[i].ctl[1], vt[i].ctl[0]);
      chk($sformatf("vec%0d_flags", i), {evValid, evExt, evBreak, protoErr}, vt[i].fl);
      chk($sformatf("vec%0d_code", i), evCode, vt[i].code);
      chk($sformatf("vec%0d_key", i), {keyHi, keyLo}, vt[i].key);
      chk($sformatf("vec%0d_disp", i), dispEn, vt[i].disp);
      chk($sformatf("vec%0d_full_ovf", i), {fifoFull, overflow}, 0);
    end

    // Overflow: nine makes into a depth-8 FIFO.
    do_reset();
    for (int i = 0; i < 8; i++) step(8'h15 + 8'(i), 1'b1, 1'b0, 1'b0);
    chk("ovf_full8", {fifoFull, overflow}, 2'b10);
    step(8'h1D, 1'b1, 1'b0, 1'b0);
    chk("ovf_full9", {fifoFull, overflow}, 2'b11);
    for (int i = 0; i < 8; i++) begin
      chk_head($sformatf("ovf_rd%0d", i), 8'h15 + 8'(i), 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("ovf_drained", evValid, 0);
    chk("ovf_sticky", overflow, 1);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", overflow, 0);

    // Pointer wrap, then push+pop while full.
    for (int i = 0; i < 8; i++) step(8'h30 + 8'(i), 1'b1, 1'b0, 1'b0);
    step(8'h2A, 1'b1, 1'b1, 1'b0);
    chk("pp_full", {fifoFull, overflow}, 2'b10);
    chk_head("pp_head", 8'h31, 1'b0, 1'b0);
    chk("pp_key", {keyHi, keyLo}, 8'h2A);
    for (int i = 0; i < 7; i++) step(8'h00, 1'b0, 1'b1, 1'b0);
    chk_head("pp_last", 8'h2A, 1'b0, 1'b0);

    // Prefix timeout.
    do_reset();
    step(8'hF0, 1'b1, 1'b0, 1'b0);
    repeat (TO - 10) step(8'h00, 1'b0, 1'b0, 1'b0);
    chk("to_early", protoErr, 0);
    repeat (10) step(8'h00, 1'b0, 1'b0, 1'b0);
    chk("to_set", {protoErr, evValid}, 2'b10);
    step(8'h1C, 1'b1, 1'b0, 1'b0);
    chk_head("to_make", 8'h1C, 1'b0, 1'b0);

    // Reset mid-prefix with a non-empty FIFO discards everything.
    step(8'hE0, 1'b1, 1'b0, 1'b0);
    do_reset();
    chk("mid_rst", {evValid, protoErr, dispEn}, 0);
    step(8'h1C, 1'b1, 1'b0, 1'b0);
    chk_head("mid_make", 8'h1C, 1'b0, 1'b0);

    // Typematic repeats.
    begin
      int n;
      int exp_n;
      logic [9:0] first, last;
`ifdef PS2_SCAN_DECODER_TYPEMATIC_FILTER_EN
      exp_n = 2;
`else
      exp_n = 4;
`endif
      do_reset();
      repeat (3) step(8'h1C, 1'b1, 1'b0, 1'b0);
      step(8'hF0, 1'b1, 1'b0, 1'b0);
      step(8'h1C, 1'b1, 1'b0, 1'b0);
      n = 0; first = '0; last = '0;
      for (int i = 0; i < 12 && evValid; i++) begin
        if (n == 0) first = {evExt, evBreak, evCode};
        last = {evExt, evBreak, evCode};
        n++;
        step(8'h00, 1'b0, 1'b1, 1'b0);
      end
      chk("rep_count", n, exp_n);
      chk("rep_first", first, 10'h01C);
      chk("rep_last", last, 10'h11C);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
